// File: rtl/fpcvt_pkg.sv
// Shared constants, result layout and exponent mapping for the integer-to-fp8 converter.
package fpcvt_pkg;

  localparam int unsigned IN_W  = 12;
  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;

  localparam logic [EXP_W-1:0] E_MAX = 3'd7;
  localparam logic [SIG_W-1:0] F_MAX = 4'hF;

  // Result byte: value = (-1)^sign * sig * 2^exp
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp8_t;

  // Leading-zero count of the 12-bit magnitude -> exponent. The window is 4 bits wide, so a
  // leading one at bit p (L = 11 - p) needs a shift of p - 3 = 8 - L, floored at zero.
  function automatic logic [EXP_W-1:0] lzc_to_exp(input logic [3:0] lz);
    logic [EXP_W-1:0] e;
    if (lz == 4'd0) begin
      // Magnitude bit 11 is never set; clamp rather than wrap if it ever were.
      e = E_MAX;
    end else if (lz >= 4'd8) begin
      e = '0;
    end else begin
      e = 3'(4'd8 - lz);
    end
    return e;
  endfunction

endpackage

// File: rtl/fpcvt_if.sv
// Producer/consumer bundle for the converter: integer sample in, fp8 result out.
interface fpcvt_if;
  import fpcvt_pkg::*;

  logic            in_valid;
  logic [IN_W-1:0] d_in;
  logic            out_valid;
  logic [7:0]      d_out;

  // Producer / testbench side
  modport master (
    output in_valid,
    output d_in,
    input  out_valid,
    input  d_out
  );

  // Converter side
  modport slave (
    input  in_valid,
    input  d_in,
    output out_valid,
    output d_out
  );

endinterface

// File: rtl/fpcvt_lzc.sv
// Combinational 12-bit leading-zero counter; all-zero input reports 12.
module fpcvt_lzc (
  input  logic [11:0] data_i,
  output logic [3:0]  lzc_o
);

  // Scan upward so the highest set bit is the last one to write the result.
  always_comb begin
    lzc_o = 4'd12;
    for (int i = 0; i < 12; i++) begin
      if (data_i[i]) begin
        lzc_o = 4'(11 - i);
      end
    end
  end

endmodule

// File: rtl/fpcvt_main.sv
// 12-bit two's-complement integer to fp8 {S, E[2:0], F[3:0]} converter, round-half-up with
// saturation at 15 * 2^7. Default latency is 1 cycle; defining FPCVT_IN_REG_EN adds an input
// register stage (latency 2) with identical results.
module fpcvt_main
  import fpcvt_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  fpcvt_if.slave bus
);

  logic            stage_valid;
  logic [IN_W-1:0] stage_din;

`ifdef FPCVT_IN_REG_EN
  logic            in_valid_q;
  logic [IN_W-1:0] d_in_q;

  // Optional input stage, cleared by reset along with the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      d_in_q     <= '0;
    end else begin
      in_valid_q <= bus.in_valid;
      d_in_q     <= bus.d_in;
    end
  end

  assign stage_valid = in_valid_q;
  assign stage_din   = d_in_q;
`else
  assign stage_valid = bus.in_valid;
  assign stage_din   = bus.d_in;
`endif

  logic        sign;
  logic        is_min;
  logic [10:0] mag;
  logic [3:0]  lz;

  // Sign/magnitude split; -2048 has no 11-bit magnitude and is flagged for saturation.
  always_comb begin
    sign   = stage_din[IN_W-1];
    is_min = (stage_din == 12'h800);
    mag    = sign ? 11'(-stage_din) : stage_din[10:0];
  end

  fpcvt_lzc u_lzc (
    .data_i ({1'b0, mag}),
    .lzc_o  (lz)
  );

  logic [EXP_W-1:0] exp_raw;
  logic [SIG_W-1:0] sig_raw;
  logic             rnd_bit;
  logic [SIG_W:0]   sig_rnd;
  logic [EXP_W:0]   exp_inc;
  fp8_t             res;

  // Extract the 4-bit window, round half up, renormalise on carry-out, then saturate.
  always_comb begin
    exp_raw = lzc_to_exp(lz);
    sig_raw = 4'(mag >> exp_raw);
    // The appended zero makes exp_raw = 0 yield no rounding; otherwise this is mag[exp_raw-1].
    rnd_bit = 1'({mag, 1'b0} >> exp_raw);
    sig_rnd = {1'b0, sig_raw} + {4'd0, rnd_bit};
    exp_inc = {1'b0, exp_raw} + {3'd0, sig_rnd[SIG_W]};

    res.sign = sign;
    // exp_inc[3] means the exponent passed E_MAX (7) after renormalisation.
    if (is_min || exp_inc[EXP_W]) begin
      res.exp = E_MAX;
      res.sig = F_MAX;
    end else begin
      res.exp = exp_inc[EXP_W-1:0];
      res.sig = sig_rnd[SIG_W] ? 4'b1000 : sig_rnd[SIG_W-1:0];
    end
  end

  logic out_valid_q, out_valid_d;
  fp8_t d_out_q, d_out_d;

  // Capture a new result only for valid samples; otherwise hold the last one.
  always_comb begin
    out_valid_d = stage_valid;
    d_out_d     = stage_valid ? res : d_out_q;
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      d_out_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      d_out_q     <= d_out_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.d_out     = d_out_q;

endmodule

// File: tb/tb_fpcvt_main.sv
// Directed self-checking bench for fpcvt_main; latency follows FPCVT_IN_REG_EN.
module tb_fpcvt_main;

`ifdef FPCVT_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fpcvt_if bus ();

  fpcvt_main dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle 1 time unit so sampling is away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one valid sample for one cycle, then idle until its result is visible.
  task automatic send(input logic [11:0] v);
    bus.in_valid = 1'b1;
    bus.d_in     = v;
    step();
    bus.in_valid = 1'b0;
    for (int i = 1; i < LAT; i++) step();
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.d_in     = 12'd44;
    step();
    step();
    checks++;
    if (bus.d_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_dout got=%h want=%h", bus.d_out, 8'h00);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b want=%b", bus.out_valid, 1'b0);
    end
    // First sample after release: 46 -> 0_010_1100
    rst      = 1'b0;
    bus.d_in = 12'd46;
    step();
    bus.in_valid = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.d_out !== 8'h2C) begin
      failures++;
      $display("FAIL reset_first got=%b/%h want=1/%h", bus.out_valid, bus.d_out, 8'h2C);
    end
  endtask

  task automatic test_rounding();
    logic [11:0] vin [4] = '{12'd44, 12'd45, 12'd46, 12'd47};
    logic [7:0]  vexp[4] = '{8'h2B, 8'h2B, 8'h2C, 8'h2C};
    for (int i = 0; i < 4; i++) begin
      send(vin[i]);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.d_out !== vexp[i]) begin
        failures++;
        $display("FAIL rounding in=%0d got=%b/%h want=1/%h", vin[i], bus.out_valid,
                 bus.d_out, vexp[i]);
      end
    end
  endtask

  task automatic test_negative();
    // -46 -> 1_010_1100, -1 -> 1_000_0001, 0 -> 00
    logic [11:0] vin [3] = '{-12'sd46, -12'sd1, 12'd0};
    logic [7:0]  vexp[3] = '{8'hAC, 8'h81, 8'h00};
    for (int i = 0; i < 3; i++) begin
      send(vin[i]);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.d_out !== vexp[i]) begin
        failures++;
        $display("FAIL negative in=%h got=%b/%h want=1/%h", vin[i], bus.out_valid,
                 bus.d_out, vexp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    // 31: F=1111 rounds up -> F=1000, E=2 (value 32) -> 0_010_1000. 15 is exact at E=0.
    logic [11:0] vin [2] = '{12'd31, 12'd15};
    logic [7:0]  vexp[2] = '{8'h28, 8'h0F};
    for (int i = 0; i < 2; i++) begin
      send(vin[i]);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.d_out !== vexp[i]) begin
        failures++;
        $display("FAIL overflow in=%0d got=%b/%h want=1/%h", vin[i], bus.out_valid,
                 bus.d_out, vexp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [11:0] vin [3] = '{12'd2047, 12'h800, 12'd1920};
    logic [7:0]  vexp[3] = '{8'h7F, 8'hFF, 8'h7F};
    for (int i = 0; i < 3; i++) begin
      send(vin[i]);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.d_out !== vexp[i]) begin
        failures++;
        $display("FAIL saturation in=%h got=%b/%h want=1/%h", vin[i], bus.out_valid,
                 bus.d_out, vexp[i]);
      end
    end
  endtask

  task automatic test_hold();
    // Last result was 1920 -> 7F; idle cycles must drop valid and keep d_out.
    bus.in_valid = 1'b0;
    bus.d_in     = 12'd5;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.d_out !== 8'h7F) begin
        failures++;
        $display("FAIL hold cyc=%0d got=%b/%h want=0/%h", i, bus.out_valid, bus.d_out, 8'h7F);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Inputs per edge: 44, 46, gap, -3, idle...
    logic        iv [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] id [5] = '{12'd44, 12'd46, 12'd0, -12'sd3, 12'd0};
    logic        ev [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  ed [5] = '{8'h2B, 8'h2C, 8'h2C, 8'h83, 8'h83};
    for (int k = 1; k <= 4 + LAT; k++) begin
      if (k <= 5) begin
        bus.in_valid = iv[k-1];
        bus.d_in     = id[k-1];
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (k >= LAT) begin
        checks++;
        if (bus.out_valid !== ev[k-LAT] || bus.d_out !== ed[k-LAT]) begin
          failures++;
          $display("FAIL b2b edge=%0d got=%b/%h want=%b/%h", k, bus.out_valid, bus.d_out,
                   ev[k-LAT], ed[k-LAT]);
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.d_in     = '0;
    test_reset();
    test_rounding();
    test_negative();
    test_overflow();
    test_saturation();
    test_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
